tick_gen: RTL and testbench

TICK_GEN -- requirements
Module: tick_gen

---
 rtl/tick_gen.sv | 139 +++++++++++++
 tb/tb_tick_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tick_gen.sv
// tick_gen: programmable periodic tick generator.
// A run-level-controlled FSM (IDLE -> LOAD -> RUN -> DONE) latches a period
// and a tick limit, then emits one-clk tick pulses every period clk cycles
// until the limit is reached (limit 0 = free-run).
// Optional feature macro: TICK_GEN_HOLD_EN enables the hold (pause) input.
module tick_gen #(
    parameter int CNT_W      = 16,
    parameter int PERIOD_DEF = 22
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             run,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] limit,
    input  logic             hold,
    output logic             tick,
    output logic [CNT_W-1:0] tick_count,
    output logic             reached,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e           state_q,    state_d;
    logic [CNT_W-1:0] period_l_q, period_l_d;
    logic [CNT_W-1:0] limit_l_q,  limit_l_d;
    logic [CNT_W-1:0] presc_q,    presc_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic             tick_q,     tick_d;
    logic             reached_q,  reached_d;

    logic [CNT_W-1:0] count_inc;
    logic             period_hit;
    logic             hold_eff;

`ifdef TICK_GEN_HOLD_EN
    // Pause request is live: freezes the prescaler and tick counter in RUN.
    assign hold_eff = hold;
`else
    // Port kept so both builds share one interface; pause is disabled.
    assign hold_eff = hold & 1'b0;
`endif

    // Terminal prescaler value and the tick count after the pending tick.
    assign period_hit = (presc_q == (period_l_q - 1'b1));
    assign count_inc  = count_q + 1'b1;

    // Next-state and datapath update; run=0 overrides everything else.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        period_l_d = period_l_q;
        limit_l_d  = limit_l_q;
        presc_d    = presc_q;
        count_d    = count_q;
        tick_d     = 1'b0;
        reached_d  = reached_q;

        if (!run) begin
            // Abort: also wins over a coincident terminal tick.
            state_d   = IDLE;
            presc_d   = '0;
            count_d   = '0;
            reached_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = LOAD;
                end
                LOAD: begin
                    period_l_d = (period == '0) ? CNT_W'(PERIOD_DEF) : period;
                    limit_l_d  = limit;
                    presc_d    = '0;
                    count_d    = '0;
                    reached_d  = 1'b0;
                    state_d    = RUN;
                end
                RUN: begin
                    if (hold_eff) begin
                        // Paused: prescaler and count keep their values.
                        presc_d = presc_q;
                    end else if (period_hit) begin
                        tick_d  = 1'b1;
                        presc_d = '0;
                        count_d = count_inc;
                        if ((limit_l_q != '0) && (count_inc == limit_l_q)) begin
                            reached_d = 1'b1;
                            state_d   = DONE;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                DONE: begin
                    // Frozen until run falls; a new cycle needs a fresh rise.
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge clear) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its peers.
        if (clear) begin
            state_q    <= IDLE;
            period_l_q <= '0;
            limit_l_q  <= '0;
            presc_q    <= '0;
            count_q    <= '0;
            tick_q     <= 1'b0;
            reached_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            period_l_q <= period_l_d;
            limit_l_q  <= limit_l_d;
            presc_q    <= presc_d;
            count_q    <= count_d;
            tick_q     <= tick_d;
            reached_q  <= reached_d;
        end
    end

    assign tick       = tick_q;
    assign tick_count = count_q;
    assign reached    = reached_q;
    assign busy       = (state_q == LOAD) || (state_q == RUN);

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: directed self-checking bench for tick_gen.
// Honours TICK_GEN_HOLD_EN when choosing the expected pause behaviour.
module tb_tick_gen;

    localparam int CNT_W = 16;

    logic             clk;
    logic             clear;
    logic             run;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] limit;
    logic             hold;
    logic             tick;
    logic [CNT_W-1:0] tick_count;
    logic             reached;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;

    tick_gen #(
        .CNT_W     (CNT_W),
        .PERIOD_DEF(22)
    ) dut (
        .clk       (clk),
        .clear     (clear),
        .run       (run),
        .period    (period),
        .limit     (limit),
        .hold      (hold),
        .tick      (tick),
        .tick_count(tick_count),
        .reached   (reached),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, and report tag/observed/expected on a miss.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; inputs change and outputs are sampled 1ns after.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Edges until tick is seen high, bounded by max_cyc (returns max_cyc on timeout).
    task automatic wait_tick(input int max_cyc, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!tick && n < max_cyc);
    endtask

    initial begin
        int n;
        int bad;
        int hold_exp;

        clear  = 1'b1;
        run    = 1'b0;
        period = '0;
        limit  = '0;
        hold   = 1'b0;

        // Reset state while clear is held.
        #1;
        check("rst_tick",    tick,       0);
        check("rst_count",   tick_count, 0);
        check("rst_reached", reached,    0);
        check("rst_busy",    busy,       0);
        step(2);
        #2 clear = 1'b0;

        // period=4, limit=3: LOAD one cycle, ticks every 4 RUN cycles.
        period = 16'd4;
        limit  = 16'd3;
        run    = 1'b1;
        step(1);
        check("t1_load_busy", busy, 1);
        check("t1_load_tick", tick, 0);
        step(1);
        check("t1_run_busy",  busy, 1);
        check("t1_run_count", tick_count, 0);
        // Changes after LOAD must be ignored.
        period = 16'd9;
        limit  = 16'd7;
        wait_tick(20, n);
        check("t1_gap1", n, 4);
        check("t1_cnt1", tick_count, 1);
        step(1);
        check("t1_pulse_width", tick, 0);
        wait_tick(20, n);
        check("t1_gap2", n, 3);
        check("t1_cnt2", tick_count, 2);
        check("t1_reached_early", reached, 0);
        wait_tick(20, n);
        check("t1_gap3", n, 4);
        check("t1_cnt3",    tick_count, 3);
        check("t1_reached", reached,    1);
        check("t1_busy_done", busy,     0);
        step(1);
        check("t1_done_tick",    tick,       0);
        check("t1_done_count",   tick_count, 3);
        check("t1_done_reached", reached,    1);
        // run still high: DONE must not restart.
        step(6);
        check("t1_done_hold_tick",  tick,       0);
        check("t1_done_hold_count", tick_count, 3);
        check("t1_done_hold_busy",  busy,       0);
        run = 1'b0;
        step(1);
        check("t1_idle_reached", reached,    0);
        check("t1_idle_count",   tick_count, 0);

        // period=0 -> default 22, limit=2: reached after 44 RUN cycles.
        period = 16'd0;
        limit  = 16'd2;
        run    = 1'b1;
        step(2);
        wait_tick(60, n);
        check("t2_gap1", n, 22);
        check("t2_reached1", reached, 0);
        wait_tick(60, n);
        check("t2_gap2", n, 22);
        check("t2_cnt",     tick_count, 2);
        check("t2_reached", reached,    1);
        run = 1'b0;
        step(1);

        // period=1, limit=0 for 70000 cycles: tick constant, count wraps.
        period = 16'd1;
        limit  = 16'd0;
        run    = 1'b1;
        step(2);
        bad = 0;
        for (int i = 1; i <= 70000; i++) begin
            step(1);
            if (tick !== 1'b1 || reached !== 1'b0 || tick_count !== CNT_W'(i))
                bad++;
            if (i == 65535) check("t3_count_max",  tick_count, 65535);
            if (i == 65536) check("t3_count_wrap", tick_count, 0);
        end
        check("t3_bad_cycles", bad, 0);
        check("t3_reached", reached, 0);
        run = 1'b0;
        step(1);

        // period=5, limit=2: run drops on the edge of the terminal tick.
        period = 16'd5;
        limit  = 16'd2;
        run    = 1'b1;
        step(2);
        wait_tick(20, n);
        check("t4_gap1", n, 5);
        step(4);
        check("t4_pre_tick", tick, 0);
        run = 1'b0;
        step(1);
        check("t4_tick",    tick,       0);
        check("t4_reached", reached,    0);
        check("t4_count",   tick_count, 0);
        check("t4_busy",    busy,       0);

        // clear pulsed mid-RUN at tick_count=7.
        period = 16'd2;
        limit  = 16'd0;
        run    = 1'b1;
        step(2);
        for (int k = 0; k < 7; k++) wait_tick(10, n);
        check("t5_count7", tick_count, 7);
        #2 clear = 1'b1;
        #1;
        check("t5_clr_tick",    tick,       0);
        check("t5_clr_count",   tick_count, 0);
        check("t5_clr_reached", reached,    0);
        check("t5_clr_busy",    busy,       0);
        step(1);
        clear = 1'b0;
        step(1);
        check("t5_load_busy",  busy,       1);
        check("t5_load_count", tick_count, 0);
        step(1);
        wait_tick(10, n);
        check("t5_gap1", n, 2);
        check("t5_cnt1", tick_count, 1);
        run = 1'b0;
        step(1);

        // Hold for 10 cycles after the 1st tick.
`ifdef TICK_GEN_HOLD_EN
        hold_exp = 14;
`else
        hold_exp = 4;
`endif
        period = 16'd4;
        limit  = 16'd2;
        run    = 1'b1;
        step(2);
        wait_tick(20, n);
        check("t6_gap1", n, 4);
        hold = 1'b1;
        n = 0;
        do begin
            step(1);
            n++;
            if (n == 10) hold = 1'b0;
        end while (!tick && n < 40);
        hold = 1'b0;
        check("t6_gap2",    n,          hold_exp);
        check("t6_cnt",     tick_count, 2);
        check("t6_reached", reached,    1);
        run = 1'b0;
        step(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
